// File: rtl/fc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fc_ctrl_pkg
//
// Shared types and helpers for the fully-connected layer controller.
//
// Contents:
//   fc_state_t  - controller state encoding (IDLE, LOAD, ISSUE, FLUSH, OUTPUT)
//   cnt_width() - counter width for a count range of n values.
//                 Always at least 1 bit, so that a degenerate range such as
//                 M = 1 still gets a legal vector.
//   STALL_W     - width of the optional stall counter
// -----------------------------------------------------------------------------
package fc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        FLUSH,
        OUTPUT
    } fc_state_t;

    localparam int STALL_W = 32;

    // Bits needed to hold the values 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fc_ctrl_counter.sv
// -----------------------------------------------------------------------------
// fc_ctrl_counter
//
// Wrap counter with synchronous clear. It counts 0 .. max, and an increment
// at max returns it to 0. wrap flags the increment that causes the return to 0.
//
// Parameters:
//   W      counter width
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset; value -> 0
//   clr    in   synchronous clear; has priority over inc
//   inc    in   advance the count by one
//   max    in   terminal count
//   value  out  current count
//   wrap   out  inc while value == max (combinational)
// -----------------------------------------------------------------------------
module fc_ctrl_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max,
    output logic [W-1:0] value,
    output logic         wrap
);

    assign wrap = inc && (value == max);

    // NOTE: state registers are written with <= so that every flop samples
    // the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (inc) begin
            value <= wrap ? '0 : value + W'(1);
        end
    end

endmodule

// File: rtl/fc_layer_ctrl.sv
// -----------------------------------------------------------------------------
// fc_layer_ctrl
//
// Sequencing controller for one fully-connected layer. It loads an N-element
// input vector into the layer's input memory. For each of the M rows it then
// walks the weight ROM and drives the accumulator's clear/enable strobes,
// and it presents each row result to the downstream layer. The datapath
// (memories, MAC, activation) lives outside this block.
//
// Optional feature (macro FC_LAYER_CTRL_PERF_EN):
//   Adds output stall_cnt. It is a saturating count of the cycles in which a
//   result was offered but the downstream layer did not take it.
//
// Parameters:
//   N   input vector length (>= 2)
//   M   output vector length (>= 1)
//   AX  input-memory address width
//   AW  weight-ROM address width
//
// Ports:
//   clk        in   clock
//   reset      in   asynchronous active-low reset
//   s_valid_x  in   upstream input word valid
//   s_ready_x  out  controller accepts an input word (LOAD only)
//   wr_en_x    out  input-memory write strobe
//   addr_x     out  input-memory address (write in LOAD, read in ISSUE)
//   addr_w     out  weight-ROM read address
//   clear_acc  out  accumulator loads the product instead of adding it
//   en_acc     out  accumulator update enable
//   m_valid_y  out  row result valid to downstream
//   m_ready_y  in   downstream accepts the result
//   stall_cnt  out  (FC_LAYER_CTRL_PERF_EN only) output stall cycles
// -----------------------------------------------------------------------------
module fc_layer_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int N  = 8,
    parameter int M  = 4,
    parameter int AX = $clog2(N),
    parameter int AW = $clog2(M * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid_x,
    output logic          s_ready_x,
    output logic          wr_en_x,
    output logic [AX-1:0] addr_x,
    output logic [AW-1:0] addr_w,
    output logic          clear_acc,
    output logic          en_acc,
    output logic          m_valid_y,
    input  logic          m_ready_y
`ifdef FC_LAYER_CTRL_PERF_EN
    ,
    output logic [STALL_W-1:0] stall_cnt
`endif
);

    localparam int RW = cnt_width(M);

    localparam logic [AX-1:0] COL_MAX = AX'(N - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(M - 1);
    localparam logic [AW-1:0] WGT_MAX = AW'(M * N - 1);

    fc_state_t     state;
    logic          handshake;
    logic          col_wrap;
    logic          row_wrap;
    logic          wgt_wrap;
    logic [RW-1:0] row;

    assign s_ready_x = (state == LOAD);
    assign wr_en_x   = s_valid_x && s_ready_x;
    assign m_valid_y = (state == OUTPUT);
    assign handshake = m_valid_y && m_ready_y;

    // -------------------------------------------------------------------------
    // Counters
    // -------------------------------------------------------------------------
    // One counter serves as the load count in LOAD and as the column in ISSUE.
    // Both phases end on its wrap, so it is already back at 0 whenever the
    // next phase starts. Its value is also the input-memory address in both
    // phases.
    fc_ctrl_counter #(.W(AX)) u_col_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .inc   (wr_en_x || (state == ISSUE)),
        .max   (COL_MAX),
        .value (addr_x),
        .wrap  (col_wrap)
    );

    // The row count advances once per delivered result. Its wrap marks the
    // final result of the vector.
    fc_ctrl_counter #(.W(RW)) u_row_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state == IDLE),
        .inc   (handshake),
        .max   (ROW_MAX),
        .value (row),
        .wrap  (row_wrap)
    );

    // The weight address is a running count of issued products. This equals
    // row*N + col without needing a multiplier. It is held at 0 while a new
    // vector loads.
    fc_ctrl_counter #(.W(AW)) u_wgt_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   ((state == IDLE) || (state == LOAD)),
        .inc   (state == ISSUE),
        .max   (WGT_MAX),
        .value (addr_w),
        .wrap  (wgt_wrap)
    );

    // The row value and the weight wrap are kept for observability only. The
    // control flow needs just the row wrap and the column wrap.
    logic unused_cnt;
    assign unused_cnt = ^{row, wgt_wrap};

    // -------------------------------------------------------------------------
    // Control FSM and accumulator strobes
    // -------------------------------------------------------------------------
    // The memories have one cycle of read latency. The accumulator strobes are
    // therefore the issue-phase conditions delayed by one register. The last
    // product of a row lands during FLUSH, so the sum is complete in the first
    // OUTPUT cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            en_acc    <= 1'b0;
            clear_acc <= 1'b0;
        end else begin
            en_acc    <= (state == ISSUE);
            clear_acc <= (state == ISSUE) && (addr_x == '0);

            case (state)
                IDLE: state <= LOAD;

                LOAD: begin
                    if (col_wrap) begin
                        state <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (col_wrap) begin
                        state <= FLUSH;
                    end
                end

                FLUSH: state <= OUTPUT;

                OUTPUT: begin
                    if (handshake) begin
                        state <= row_wrap ? LOAD : ISSUE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef FC_LAYER_CTRL_PERF_EN
    // -------------------------------------------------------------------------
    // Output stall counter. It saturates rather than wrapping, so that a
    // long-stalled run never reads back as a small number.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (m_valid_y && !m_ready_y && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_ctrl
//
// Directed bench for fc_layer_ctrl (N=8, M=4). A small behavioural datapath
// surrounds the controller: an input memory, a weight ROM with a fixed
// formula, and a MAC. The bench computes every expected row result directly
// as a dot product of the vector it sent and the ROM contents.
// Build with FC_LAYER_CTRL_PERF_EN defined to also exercise stall_cnt.
// -----------------------------------------------------------------------------
module tb_fc_layer_ctrl;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int AX = $clog2(N);
    localparam int AW = $clog2(M * N);
    localparam int OW = 5 + AX + AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid_x;
    logic          s_ready_x;
    logic          wr_en_x;
    logic [AX-1:0] addr_x;
    logic [AW-1:0] addr_w;
    logic          clear_acc;
    logic          en_acc;
    logic          m_valid_y;
    logic          m_ready_y;
`ifdef FC_LAYER_CTRL_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    logic [7:0]    x_data;

    int n_vec      = 0;
    int n_miss     = 0;
    int cyc        = 0;
    int exp_stalls = 0;

    always #5 clk = ~clk;

    fc_layer_ctrl #(.N(N), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid_x (s_valid_x),
        .s_ready_x (s_ready_x),
        .wr_en_x   (wr_en_x),
        .addr_x    (addr_x),
        .addr_w    (addr_w),
        .clear_acc (clear_acc),
        .en_acc    (en_acc),
        .m_valid_y (m_valid_y),
        .m_ready_y (m_ready_y)
`ifdef FC_LAYER_CTRL_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // ---------------- behavioural datapath ----------------
    logic [7:0]  x_mem [N];
    logic [7:0]  rd_x;
    logic [7:0]  rd_w;
    logic [31:0] acc;

    function automatic logic [7:0] w_of(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (wr_en_x) x_mem[addr_x] <= x_data;
        rd_x <= x_mem[addr_x];
        rd_w <= w_of(int'(addr_w));
        if (en_acc) acc <= (clear_acc ? 32'd0 : acc) + 32'(rd_x) * 32'(rd_w);
    end

    function automatic logic [31:0] exp_y(input logic [7:0] v [N], input int r);
        logic [31:0] s = '0;
        for (int c = 0; c < N; c++) s = s + 32'(v[c]) * 32'(w_of(r * N + c));
        return s;
    endfunction

    function automatic logic [OW-1:0] outs();
        return {s_ready_x, wr_en_x, clear_acc, en_acc, m_valid_y, addr_x, addr_w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // ---------------- one full vector with monitoring ----------------
    // Drives a vector and monitors the controller until all M results have
    // been taken. valid_pct and ready_pct set the percentage of cycles in
    // which s_valid_x and m_ready_y are high. A non-zero stall_n instead
    // holds m_ready_y low for stall_n OUTPUT cycles of every row.
    task automatic run_vector(input int valid_pct, input int ready_pct,
                              input int stall_n, input bit check_timing);
        int k = 0, res = 0, exp_w = 0, budget = 0, out_cyc = 0;
        int issue_start = -1, last_hs = -1;
        logic [7:0] vx [N];
        logic [AW-1:0] prev_aw = '0;
        logic [AX-1:0] prev_ax = '0;
        logic prev_valid = 1'b0, prev_hs = 1'b0, hs;

        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        while (s_ready_x !== 1'b1 && budget < 20) begin
            tick();
            budget++;
        end
        n_vec++;
        if (s_ready_x !== 1'b1)
            $display("FAIL load_entry: s_ready_x=%b want 1", s_ready_x);

        budget = 0;
        while (res < M && budget < 3000) begin
            if (stall_n > 0) m_ready_y = (out_cyc >= stall_n);
            else             m_ready_y = ($urandom_range(99) < ready_pct);
            s_valid_x = ($urandom_range(99) < valid_pct);
            x_data    = 8'($urandom_range(255));
            #1;

            n_vec++;
            if (s_ready_x !== (k < N)) begin
                n_miss++;
                $display("FAIL ready_phase: s_ready_x=%b want %b (cycle %0d)", s_ready_x, (k < N), cyc);
            end
            n_vec++;
            if (wr_en_x !== (s_valid_x && k < N)) begin
                n_miss++;
                $display("FAIL write_strobe: wr_en_x=%b want %b (cycle %0d)", wr_en_x, (s_valid_x && k < N), cyc);
            end
            if (wr_en_x === 1'b1 && k < N) begin
                n_vec++;
                if (addr_x !== AX'(k)) begin
                    n_miss++;
                    $display("FAIL write_addr: addr_x=%0d want %0d", addr_x, k);
                end
                vx[k] = x_data;
                k++;
                if (k == N) issue_start = cyc + 1;
            end

            if (en_acc === 1'b1) begin
                n_vec++;
                if (prev_aw !== AW'(exp_w)) begin
                    n_miss++;
                    $display("FAIL weight_addr: addr_w=%0d want %0d", prev_aw, exp_w);
                end
                n_vec++;
                if (prev_ax !== AX'(exp_w % N)) begin
                    n_miss++;
                    $display("FAIL read_addr: addr_x=%0d want %0d", prev_ax, exp_w % N);
                end
                n_vec++;
                if (clear_acc !== (exp_w % N == 0)) begin
                    n_miss++;
                    $display("FAIL clear_acc: got %b want %b (product %0d)", clear_acc, (exp_w % N == 0), exp_w);
                end
                exp_w++;
            end else begin
                n_vec++;
                if (clear_acc !== 1'b0) begin
                    n_miss++;
                    $display("FAIL clear_without_en: clear_acc=%b want 0", clear_acc);
                end
            end

            if (prev_valid && !prev_hs) begin
                n_vec++;
                if (m_valid_y !== 1'b1) begin
                    n_miss++;
                    $display("FAIL valid_dropped: m_valid_y=%b want 1", m_valid_y);
                end
            end
            if (m_valid_y === 1'b1 && !prev_valid) begin
                n_vec++;
                if (cyc - issue_start != N + 1) begin
                    n_miss++;
                    $display("FAIL valid_latency: %0d cycles want %0d", cyc - issue_start, N + 1);
                end
            end

            hs = (m_valid_y === 1'b1) && m_ready_y;
            if (hs) begin
                n_vec++;
                if (acc !== exp_y(vx, res)) begin
                    n_miss++;
                    $display("FAIL y_row%0d: acc=%0d want %0d", res, acc, exp_y(vx, res));
                end
                if (check_timing && last_hs >= 0) begin
                    n_vec++;
                    if (cyc - last_hs != N + 2) begin
                        n_miss++;
                        $display("FAIL hs_spacing: %0d cycles want %0d", cyc - last_hs, N + 2);
                    end
                end
                last_hs = cyc;
                res++;
                out_cyc = 0;
                if (res < M) issue_start = cyc + 1;
            end else if (m_valid_y === 1'b1) begin
                out_cyc++;
                exp_stalls++;
            end

            prev_valid = (m_valid_y === 1'b1);
            prev_hs    = hs;
            prev_aw    = addr_w;
            prev_ax    = addr_x;
            tick();
            budget++;
        end
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;

        n_vec++;
        if (res != M) begin
            n_miss++;
            $display("FAIL results_count: %0d results want %0d", res, M);
        end
        n_vec++;
        if (k != N) begin
            n_miss++;
            $display("FAIL writes_count: %0d writes want %0d", k, N);
        end
        n_vec++;
        if (exp_w != M * N) begin
            n_miss++;
            $display("FAIL issue_count: %0d products want %0d", exp_w, M * N);
        end
        n_vec++;
        if (s_ready_x !== 1'b1) begin
            n_miss++;
            $display("FAIL reload_ready: s_ready_x=%b want 1", s_ready_x);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset     = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        x_data    = '0;
        repeat (3) begin
            tick();
            n_vec++;
            if (outs() !== '0) begin
                n_miss++;
                $display("FAIL reset_outputs: got %h want 0", outs());
            end
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (outs() !== '0) begin
            n_miss++;
            $display("FAIL idle_outputs: got %h want 0", outs());
        end
        repeat (4) begin
            tick();
            n_vec++;
            if (s_ready_x !== 1'b1) begin
                n_miss++;
                $display("FAIL load_ready: s_ready_x=%b want 1", s_ready_x);
            end
            n_vec++;
            if ({wr_en_x, clear_acc, en_acc, m_valid_y, addr_x, addr_w} !== '0) begin
                n_miss++;
                $display("FAIL load_quiet: got %h want 0", {wr_en_x, clear_acc, en_acc, m_valid_y, addr_x, addr_w});
            end
        end
    endtask

    task automatic test_full_vector();
        run_vector(100, 100, 0, 1'b1);
    endtask

    task automatic test_valid_ignored();
        // s_valid_x stays high through ISSUE/FLUSH/OUTPUT.
        run_vector(100, 50, 0, 1'b0);
        run_vector(100, 100, 0, 1'b1);
    endtask

    task automatic test_random_gaps();
        for (int v = 0; v < 100; v++) run_vector(50, 50, 0, 1'b0);
    endtask

    task automatic test_mid_reset();
        int k = 0, budget = 0;
        m_ready_y = 1'b1;
        while (k < N && budget < 100) begin
            s_valid_x = 1'b1;
            x_data    = 8'($urandom_range(255));
            #1;
            if (wr_en_x === 1'b1) k++;
            tick();
            budget++;
        end
        s_valid_x = 1'b0;
        n_vec++;
        if (k != N) begin
            n_miss++;
            $display("FAIL mid_load: %0d writes want %0d", k, N);
        end
        // Row 2, column 3: 2*(N+2)+3 cycles after ISSUE row 0 column 0.
        repeat (2 * (N + 2) + 3) tick();
        n_vec++;
        if (addr_x !== AX'(3)) begin
            n_miss++;
            $display("FAIL mid_col: addr_x=%0d want 3", addr_x);
        end
        n_vec++;
        if (addr_w !== AW'(2 * N + 3)) begin
            n_miss++;
            $display("FAIL mid_wgt: addr_w=%0d want %0d", addr_w, 2 * N + 3);
        end
        reset = 1'b0;
        #1;
        n_vec++;
        if (outs() !== '0) begin
            n_miss++;
            $display("FAIL reset_async: got %h want 0", outs());
        end
        tick();
        n_vec++;
        if (outs() !== '0) begin
            n_miss++;
            $display("FAIL reset_hold: got %h want 0", outs());
        end
        reset = 1'b1;
        run_vector(100, 100, 0, 1'b1);
    endtask

`ifdef FC_LAYER_CTRL_PERF_EN
    task automatic test_perf_stall();
        reset     = 1'b0;
        s_valid_x = 1'b0;
        m_ready_y = 1'b0;
        tick();
        n_vec++;
        if (stall_cnt !== 32'd0) begin
            n_miss++;
            $display("FAIL stall_reset: stall_cnt=%0d want 0", stall_cnt);
        end
        reset      = 1'b1;
        exp_stalls = 0;
        run_vector(100, 0, 5, 1'b0);
        n_vec++;
        if (stall_cnt !== 32'(exp_stalls)) begin
            n_miss++;
            $display("FAIL stall_model: stall_cnt=%0d want %0d", stall_cnt, exp_stalls);
        end
        n_vec++;
        if (stall_cnt !== 32'd20) begin
            n_miss++;
            $display("FAIL stall_total: stall_cnt=%0d want 20", stall_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_vector();
        test_valid_ignored();
        test_random_gaps();
        test_mid_reset();
`ifdef FC_LAYER_CTRL_PERF_EN
        test_perf_stall();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
